// File: rtl/cordic_inv_af_seq.sv
// Inverse activation unit: atanh / logit by iterative hyperbolic vectoring CORDIC.
// One micro-rotation per clock, valid/ready handshake on input and output.
`timescale 1ns/1ps
module cordic_inv_af_seq #(
  parameter int N_BITS     = 16,
  parameter int INT_BITS   = 4,
  parameter int FRAC_BITS  = 12,
  parameter int ITERATIONS = 12,
  parameter int GUARD      = 4,
  parameter int CLAMP      = 3277
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_sat
);

  localparam int W     = N_BITS + GUARD + 2;
  localparam int FB    = FRAC_BITS + GUARD;
  localparam int STEPS = ITERATIONS + (ITERATIONS >= 4 ? 1 : 0)
                       + (ITERATIONS >= 13 ? 1 : 0);
  localparam int CW    = $clog2(STEPS + 1);
  localparam int TN    = 2 ** CW;

  localparam logic [CW-1:0] LAST = CW'(STEPS);

  localparam logic signed [W-1:0] ONE_Q  = W'(1 << (N_BITS - INT_BITS));
  localparam logic signed [W-1:0] ONE_X  = W'(1 << FB);
  localparam logic signed [W-1:0] CLMP   = W'(CLAMP);
  localparam logic signed [W-1:0] RND    = W'(1 << (GUARD - 1));
  localparam logic signed [W-1:0] MAXO   = W'((1 << (N_BITS - 1)) - 1);
  localparam logic signed [W-1:0] MINO   = -MAXO - W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Iteration index for step k; indices 4 and 13 run twice.
  function automatic int idx_of(input int k);
    int s;
    int r;
    bit found;
    s = 0;
    r = ITERATIONS;
    found = 1'b0;
    for (int i = 1; i <= ITERATIONS; i++) begin
      if (!found && s == k) begin
        r = i;
        found = 1'b1;
      end
      s++;
      if (i == 4 || i == 13) begin
        if (!found && s == k) begin
          r = i;
          found = 1'b1;
        end
        s++;
      end
    end
    return r;
  endfunction

  function automatic int atanh_q(input int i);
    real a;
    real t;
    a = 1.0 / (2.0 ** i);
    t = 0.5 * $ln((1.0 + a) / (1.0 - a));
    return $rtoi(t * (2.0 ** FB) + 0.5);
  endfunction

  logic signed [W-1:0] tbl [TN];
  logic [4:0]          shf [TN];

  for (genvar k = 0; k < TN; k++) begin : g_tbl
    localparam int IDX = (k < STEPS) ? idx_of(k) : 1;
    assign tbl[k] = (k < STEPS) ? W'(atanh_q(IDX)) : '0;
    assign shf[k] = 5'(IDX);
  end

  logic [1:0]          state;
  logic [N_BITS-1:0]   dreg;
  logic                sel_q;
  logic                clamp_q;
  logic signed [W-1:0] xr, yr, zr;
  logic [CW-1:0]       cnt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  logic signed [W-1:0] din, v_raw, v_clamp;
  logic                v_sat;

  always_comb begin
    din     = {{(W-N_BITS){dreg[N_BITS-1]}}, dreg};
    v_raw   = sel_q ? (din <<< 1) - ONE_Q : din;
    v_clamp = v_raw;
    v_sat   = 1'b0;
    if (v_raw > CLMP) begin
      v_clamp = CLMP;
      v_sat   = 1'b1;
    end else if (v_raw < -CLMP) begin
      v_clamp = -CLMP;
      v_sat   = 1'b1;
    end
  end

  logic signed [W-1:0] xs, ys, tv;
  logic signed [W-1:0] x_n, y_n, z_n;

  always_comb begin
    xs = xr >>> shf[cnt];
    ys = yr >>> shf[cnt];
    tv = tbl[cnt];
    if (!yr[W-1]) begin
      x_n = xr - ys;
      y_n = yr - xs;
      z_n = zr + tv;
    end else begin
      x_n = xr + ys;
      y_n = yr + xs;
      z_n = zr - tv;
    end
  end

  logic signed [W-1:0] r, rr;
  logic [N_BITS-1:0]   o_data;
  logic                o_sat;

  // logit doubles the angle; round half-up back to FRAC_BITS
  always_comb begin
    r      = sel_q ? (zr <<< 1) : zr;
    rr     = (r + RND) >>> GUARD;
    o_data = rr[N_BITS-1:0];
    o_sat  = 1'b0;
    if (rr > MAXO) begin
      o_data = MAXO[N_BITS-1:0];
      o_sat  = 1'b1;
    end else if (rr < MINO) begin
      o_data = MINO[N_BITS-1:0];
      o_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dreg     <= '0;
      sel_q    <= 1'b0;
      clamp_q  <= 1'b0;
      xr       <= '0;
      yr       <= '0;
      zr       <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dreg  <= in_data;
            sel_q <= in_sel;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          xr      <= ONE_X;
          yr      <= v_clamp <<< GUARD;
          zr      <= '0;
          clamp_q <= v_sat;
          cnt     <= '0;
          state   <= S_ITER;
        end
        S_ITER: begin
          if (cnt == LAST) begin
            out_data <= o_data;
            out_sat  <= clamp_q | o_sat;
            state    <= S_DONE;
          end else begin
            xr  <= x_n;
            yr  <= y_n;
            zr  <= z_n;
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_inv_af_seq.sv
// Directed and random checks for cordic_inv_af_seq against a real-number model.
// Results are compared within 3 LSB of ideal atanh/logit.
`timescale 1ns/1ps
module tb_cordic_inv_af_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_inv_af_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs,
                           input int exp, input int tol);
    n_cmp++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d+/-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic real atanh_r(input real a);
    return 0.5 * $ln((1.0 + a) / (1.0 - a));
  endfunction

  function automatic void model(input bit sel, input logic [15:0] d,
                                output int exp, output bit sat);
    int  v;
    real res;
    v = sel ? 2 * int'($signed(d)) - 4096 : int'($signed(d));
    sat = 1'b0;
    if (v > 3277) begin
      v = 3277;
      sat = 1'b1;
    end else if (v < -3277) begin
      v = -3277;
      sat = 1'b1;
    end
    res = (sel ? 2.0 : 1.0) * atanh_r(v / 4096.0) * 4096.0;
    exp = $rtoi(res >= 0.0 ? res + 0.5 : res - 0.5);
  endfunction

  task automatic do_op(input bit sel, input logic [15:0] d,
                       output int res, output bit sat, output int lat);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = int'($signed(out_data));
    sat = out_sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int  res, lat, exp, held, nv;
    bit  sat, esat, rdy, hs, sel;
    logic [15:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 16'd2048, res, sat, lat);
    check_tol("atanh_0p5", res, 2250, 3);
    check("atanh_0p5_sat", int'(sat), 0);
    check("atanh_0p5_lat", lat, 15);

    do_op(1'b1, 16'd3072, res, sat, lat);
    check_tol("logit_0p75", res, 4500, 3);
    check("logit_0p75_sat", int'(sat), 0);
    check("logit_0p75_lat", lat, 15);

    do_op(1'b1, 16'd2048, res, sat, lat);
    check_tol("logit_0p5", res, 0, 3);
    check("logit_0p5_sat", int'(sat), 0);

    do_op(1'b1, 16'd1024, res, sat, lat);
    check_tol("logit_0p25", res, -4500, 3);
    check("logit_0p25_sat", int'(sat), 0);

    do_op(1'b1, 16'd4096, res, sat, lat);
    check_tol("logit_1p0_clamp", res, 9001, 3);
    check("logit_1p0_sat", int'(sat), 1);

    do_op(1'b0, 16'd3686, res, sat, lat);
    check_tol("atanh_0p9_clamp", res, 4500, 3);
    check("atanh_0p9_sat", int'(sat), 1);

    do_op(1'b0, 16'hF000, res, sat, lat);
    check_tol("atanh_m1_clamp", res, -4500, 3);
    check("atanh_m1_sat", int'(sat), 1);

    // reset in the middle of an ITER run
    in_sel = 1'b0;
    in_data = 16'd2048;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_sat", int'(out_sat), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    check("mid_rst_no_stale", nv, 0);
    do_op(1'b0, 16'd0, res, sat, lat);
    check_tol("post_rst_zero", res, 0, 3);
    check("post_rst_sat", int'(sat), 0);
    check("post_rst_lat", lat, 15);

    // backpressure: hold out_ready low for 20 cycles
    in_sel = 1'b0;
    in_data = 16'd1024;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 15);
    held = int'($signed(out_data));
    check_tol("bp_value", held, 1046, 3);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_data = 16'h7FFF;
      in_sel = 1'b1;
      @(posedge clk); #1;
      check("bp_hold",
            int'(out_valid && !in_ready &&
                 int'($signed(out_data)) == held), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) nv++;
    end
    check("bp_pulses_ignored", nv, 0);

    // random sweep with random output backpressure
    for (int k = 0; k < 40; k++) begin
      sel = 1'($urandom_range(0, 1));
      if (k % 2 == 1) d = 16'($urandom);
      else if (!sel) d = 16'(int'($urandom_range(0, 6400)) - 3200);
      else d = 16'($urandom_range(500, 3600));
      model(sel, d, exp, esat);
      in_sel = sel;
      in_data = d;
      in_valid = 1'b1;
      rdy = 1'b0;
      for (int c = 0; c < 40 && !rdy; c++) begin
        rdy = in_ready;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("rnd_accept", int'(rdy), 1);
      hs = 1'b0;
      res = 0;
      sat = 1'b0;
      for (int c = 0; c < 80 && !hs; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        res = int'($signed(out_data));
        sat = out_sat;
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("rnd_handshake", int'(hs), 1);
      check_tol($sformatf("rnd_val_%0d", k), res, exp, 3);
      check($sformatf("rnd_sat_%0d", k), int'(sat), int'(esat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
